// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit core: FSM states, parity
// selector encodings and a constant-width helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Number of bits needed to index 'value' entries (ceil(log2(value))).
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit word FIFO. Pointers carry one extra wrap bit so that full and
// empty can be told apart without a separate occupancy register.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [clog2(DEPTH):0] count_o
);

    localparam int AW = clog2(DEPTH);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push;
    logic             pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign count_o = wr_ptr_q - rd_ptr_q;

    // Writes into a full FIFO and reads from an empty one are ignored.
    assign push = wr_en_i && !full_o;
    assign pop  = rd_en_i && !empty_o;

    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer registers; reset flushes the FIFO by equalising them.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: FIFO-buffered words are serialised as
// start / data (LSB first) / optional parity / stop bits, DIV clocks each.
// The line and done outputs are registered copies of the FSM's view, so they
// trail the state register by exactly one clock.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       sclk,
    input  logic                       RST,
    input  logic [DATA_BITS-1:0]       TX_Data,
    input  logic                       TX_En_Sig,
    output logic                       TX_Ready,
    output logic                       TX_Busy,
    output logic                       TX_Done_Sig,
    output logic [clog2(FIFO_DEPTH):0] FIFO_Count,
    output logic                       TX_Pin_Out
);

    localparam int DIV = CLK_FREQ / BAUD;
    localparam int BW  = clog2(DIV);
    localparam int IW  = clog2(DATA_BITS);
    localparam logic [BW-1:0] DIV_LAST = BW'(DIV - 1);
    localparam logic [IW-1:0] BIT_LAST = IW'(DATA_BITS - 1);

    tx_state_e            state_q, state_d;
    logic [BW-1:0]        baud_q, baud_d;
    logic [IW-1:0]        bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 pin_q, pin_d;
    logic                 done_q, done_d;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_rd_data;
    logic                 pop;
    logic                 bit_end;
    logic                 stop_last;
    logic                 frame_end;

    // Parity bit that accompanies a word for the configured mode.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
        if (PARITY == PAR_ODD)  return ~^d;
        if (PARITY == PAR_EVEN) return ^d;
        return 1'b0;
    endfunction

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (sclk),
        .rst_i     (RST),
        .wr_en_i   (TX_En_Sig),
        .wr_data_i (TX_Data),
        .rd_en_i   (pop),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (FIFO_Count)
    );

    assign bit_end   = (baud_q == DIV_LAST);
    assign stop_last = (STOP_BITS == 1) || stop_q;
    assign frame_end = (state_q == ST_STOP) && bit_end && stop_last;

    // Next-state logic: sequencing, FIFO pop and shifter load/shift.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        shift_d = shift_q;
        par_d   = par_q;
        pop     = 1'b0;
        // The counter idles at zero and restarts on every bit boundary, so a
        // new frame never inherits phase from the previous one.
        baud_d  = (state_q == ST_IDLE || bit_end) ? '0 : baud_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        stop_d  = 1'b0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    stop_d  = 1'b0;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (stop_last) begin
                        // Chain straight into the next start bit when work is queued.
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            state_d = ST_START;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (pop) begin
            shift_d = fifo_rd_data;
            par_d   = parity_bit(fifo_rd_data);
        end
    end

    // Line level for the bit the FSM is currently timing.
    always_comb begin
        pin_d = 1'b1;
        case (state_q)
            ST_START:  pin_d = 1'b0;
            ST_DATA:   pin_d = shift_q[0];
            ST_PARITY: pin_d = par_q;
            default:   pin_d = 1'b1;
        endcase
        done_d = frame_end;
    end

    // Control and output registers; reset aborts any frame and idles the line.
    always_ff @(posedge sclk or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            pin_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            pin_q   <= pin_d;
            done_q  <= done_d;
        end
    end

    // Data path registers; only meaningful after a pop loads them.
    always_ff @(posedge sclk) begin
        shift_q <= shift_d;
        par_q   <= par_d;
    end

    assign TX_Pin_Out  = pin_q;
    assign TX_Done_Sig = done_q;
    assign TX_Ready    = !fifo_full;
    // done_q covers the final stop cycle still on the line after the FSM idles.
    assign TX_Busy     = (state_q != ST_IDLE) || !fifo_empty || done_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core: directed frame checks on several configurations
// and a randomized stress run against a queue-based frame model.
module tb_uart_tx_core;

    logic sclk;
    logic RST;

    // u0: 8N1, DIV=434, depth 4
    logic [7:0] data0; logic en0, rdy0, busy0, done0, pin0; logic [2:0] cnt0;
    // u1: 8O1, DIV=434
    logic [7:0] data1; logic en1, rdy1, busy1, done1, pin1; logic [2:0] cnt1;
    // u2: 8E1, DIV=434
    logic [7:0] data2; logic en2, rdy2, busy2, done2, pin2; logic [2:0] cnt2;
    // u3: 7N2, DIV=434
    logic [6:0] data3; logic en3, rdy3, busy3, done3, pin3; logic [2:0] cnt3;
    // u4: 9E2, DIV=4, depth 2
    logic [8:0] data4; logic en4, rdy4, busy4, done4, pin4; logic [1:0] cnt4;

    int checks = 0;
    int errors = 0;

    uart_tx_core u0 (
        .sclk(sclk), .RST(RST), .TX_Data(data0), .TX_En_Sig(en0), .TX_Ready(rdy0),
        .TX_Busy(busy0), .TX_Done_Sig(done0), .FIFO_Count(cnt0), .TX_Pin_Out(pin0));

    uart_tx_core #(.PARITY(1)) u1 (
        .sclk(sclk), .RST(RST), .TX_Data(data1), .TX_En_Sig(en1), .TX_Ready(rdy1),
        .TX_Busy(busy1), .TX_Done_Sig(done1), .FIFO_Count(cnt1), .TX_Pin_Out(pin1));

    uart_tx_core #(.PARITY(2)) u2 (
        .sclk(sclk), .RST(RST), .TX_Data(data2), .TX_En_Sig(en2), .TX_Ready(rdy2),
        .TX_Busy(busy2), .TX_Done_Sig(done2), .FIFO_Count(cnt2), .TX_Pin_Out(pin2));

    uart_tx_core #(.DATA_BITS(7), .STOP_BITS(2), .PARITY(0)) u3 (
        .sclk(sclk), .RST(RST), .TX_Data(data3), .TX_En_Sig(en3), .TX_Ready(rdy3),
        .TX_Busy(busy3), .TX_Done_Sig(done3), .FIFO_Count(cnt3), .TX_Pin_Out(pin3));

    uart_tx_core #(.CLK_FREQ(400), .BAUD(100), .DATA_BITS(9), .PARITY(2),
                   .STOP_BITS(2), .FIFO_DEPTH(2)) u4 (
        .sclk(sclk), .RST(RST), .TX_Data(data4), .TX_En_Sig(en4), .TX_Ready(rdy4),
        .TX_Busy(busy4), .TX_Done_Sig(done4), .FIFO_Count(cnt4), .TX_Pin_Out(pin4));

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic pin_of(input int i);
        case (i)
            0: return pin0;
            1: return pin1;
            2: return pin2;
            3: return pin3;
            default: return pin4;
        endcase
    endfunction

    function automatic logic done_of(input int i);
        case (i)
            0: return done0;
            1: return done1;
            2: return done2;
            3: return done3;
            default: return done4;
        endcase
    endfunction

    // Expected line levels, one entry per bit: start, data LSB first, parity, stops.
    function automatic logic [15:0] frame_bits(input logic [8:0] d, input int nb, input int par);
        logic [15:0] fb;
        int k;
        int ones;
        fb = '1;
        fb[0] = 1'b0;
        k = 1;
        ones = 0;
        for (int j = 0; j < nb; j++) begin
            fb[k] = d[j];
            ones += int'(d[j]);
            k++;
        end
        if (par == 1) fb[k] = (ones % 2 == 0);
        if (par == 2) fb[k] = (ones % 2 == 1);
        return fb;
    endfunction

    // Called at the sample point of the first start-bit cycle; returns at the
    // sample point of the first cycle after the frame.
    task automatic watch_frame(input int i, input logic [8:0] d, input int nb, input int par,
                               input int stp, input int div, input string tag);
        logic [15:0] fb;
        int nbits;
        int done_idx;
        int ndone;
        fb = frame_bits(d, nb, par);
        nbits = 1 + nb + ((par != 0) ? 1 : 0) + stp;
        done_idx = -1;
        ndone = 0;
        for (int b = 0; b < nbits; b++) begin
            logic seen;
            logic bad;
            seen = fb[b];
            bad = 1'b0;
            for (int c = 0; c < div; c++) begin
                if (!bad && pin_of(i) !== fb[b]) begin
                    bad = 1'b1;
                    seen = pin_of(i);
                end
                if (done_of(i) === 1'b1) begin
                    ndone++;
                    done_idx = b * div + c;
                end
                @(negedge sclk);
            end
            check($sformatf("%s bit%0d", tag, b), {31'b0, seen}, {31'b0, fb[b]});
        end
        if (ndone > 1) done_idx = -2;
        check($sformatf("%s done_pos", tag), done_idx, nbits * div - 1);
    endtask

    task automatic write_word(input int i, input logic [8:0] d);
        case (i)
            0: begin data0 = d[7:0]; en0 = 1'b1; end
            1: begin data1 = d[7:0]; en1 = 1'b1; end
            2: begin data2 = d[7:0]; en2 = 1'b1; end
            3: begin data3 = d[6:0]; en3 = 1'b1; end
            default: begin data4 = d; en4 = 1'b1; end
        endcase
        @(negedge sclk);
        en0 = 1'b0; en1 = 1'b0; en2 = 1'b0; en3 = 1'b0; en4 = 1'b0;
    endtask

    // Single write into an idle core, latency check, then the whole frame.
    task automatic send_and_check(input int i, input logic [8:0] d, input int nb, input int par,
                                  input int stp, input string tag);
        write_word(i, d);
        @(negedge sclk);
        check({tag, " latency idle"}, {31'b0, pin_of(i)}, 32'd1);
        @(negedge sclk);
        watch_frame(i, d, nb, par, stp, 434, tag);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL global timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] bd [5];
        logic [8:0] q [$];
        logic [8:0] rw;

        RST = 1'b1;
        en0 = 0; en1 = 0; en2 = 0; en3 = 0; en4 = 0;
        data0 = '0; data1 = '0; data2 = '0; data3 = '0; data4 = '0;
        repeat (3) @(negedge sclk);

        check("reset pin", {31'b0, pin0}, 32'd1);
        check("reset done", {31'b0, done0}, 32'd0);
        check("reset busy", {31'b0, busy0}, 32'd0);
        check("reset ready", {31'b0, rdy0}, 32'd1);
        check("reset count", {29'b0, cnt0}, 32'd0);

        RST = 1'b0;
        @(negedge sclk);

        // 8N1 0x55 with explicit latency and occupancy checks
        write_word(0, 9'h055);
        check("8N1 count after write", {29'b0, cnt0}, 32'd1);
        @(negedge sclk);
        check("8N1 latency idle", {31'b0, pin0}, 32'd1);
        @(negedge sclk);
        watch_frame(0, 9'h055, 8, 0, 1, 434, "8N1");
        check("8N1 busy after", {31'b0, busy0}, 32'd0);
        check("8N1 pin after", {31'b0, pin0}, 32'd1);

        // Burst of six writes into depth-4 FIFO: sixth dropped, five frames back-to-back
        repeat (2) @(negedge sclk);
        for (int k = 0; k < 5; k++) bd[k] = 8'($urandom);
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    data0 = (k < 5) ? bd[k] : 8'hA5;
                    en0 = 1'b1;
                    if (k == 5) begin
                        check("burst ready low", {31'b0, rdy0}, 32'd0);
                        check("burst count full", {29'b0, cnt0}, 32'd4);
                    end
                    @(negedge sclk);
                end
                en0 = 1'b0;
                check("burst drop keeps count", {29'b0, cnt0}, 32'd4);
            end
            begin
                repeat (3) @(negedge sclk);
                for (int k = 0; k < 5; k++)
                    watch_frame(0, {1'b0, bd[k]}, 8, 0, 1, 434, $sformatf("burst%0d", k));
            end
        join
        check("burst busy after", {31'b0, busy0}, 32'd0);
        check("burst count after", {29'b0, cnt0}, 32'd0);

        // Reset mid-frame with two words queued
        repeat (2) @(negedge sclk);
        data0 = 8'h00;
        en0 = 1'b1;
        repeat (3) @(negedge sclk);
        en0 = 1'b0;
        check("rst count queued", {29'b0, cnt0}, 32'd2);
        repeat (1000) @(negedge sclk);
        check("rst line before", {31'b0, pin0}, 32'd0);
        #1 RST = 1'b1;
        #1;
        check("rst pin async", {31'b0, pin0}, 32'd1);
        check("rst count flushed", {29'b0, cnt0}, 32'd0);
        check("rst busy", {31'b0, busy0}, 32'd0);
        check("rst done", {31'b0, done0}, 32'd0);
        repeat (3) @(negedge sclk);
        RST = 1'b0;
        repeat (3) @(negedge sclk);
        check("rst no done after", {31'b0, done0}, 32'd0);
        check("rst line idle", {31'b0, pin0}, 32'd1);
        rw = {1'b0, 8'($urandom)};
        send_and_check(0, rw, 8, 0, 1, "post-rst");

        // Parity and stop-bit variants, directed then random word
        send_and_check(1, 9'h007, 8, 1, 1, "8O1 07");
        send_and_check(1, {1'b0, 8'($urandom)}, 8, 1, 1, "8O1 rnd");
        send_and_check(2, 9'h007, 8, 2, 1, "8E1 07");
        send_and_check(2, {1'b0, 8'($urandom)}, 8, 2, 1, "8E1 rnd");
        send_and_check(3, 9'h041, 7, 0, 2, "7N2 41");
        send_and_check(3, {2'b0, 7'($urandom)}, 7, 0, 2, "7N2 rnd");

        // Randomized stress on the 9E2 DIV=4 depth-2 core
        fork
            begin
                int acc;
                acc = 0;
                while (acc < 30) begin
                    en4 = ($urandom_range(0, 1) == 0);
                    data4 = 9'($urandom);
                    if (en4 && rdy4) begin
                        q.push_back(data4);
                        acc++;
                    end
                    @(negedge sclk);
                end
                en4 = 1'b0;
            end
            begin
                for (int f = 0; f < 30; f++) begin
                    int w;
                    logic [8:0] exp_d;
                    w = 0;
                    while (pin4 !== 1'b0 && w < 500) begin
                        @(negedge sclk);
                        w++;
                    end
                    if (w >= 500) begin
                        check("stress start timeout", {31'b0, pin4}, 32'd0);
                        break;
                    end
                    check($sformatf("stress%0d expected word", f), {31'b0, q.size() > 0}, 32'd1);
                    exp_d = (q.size() > 0) ? q.pop_front() : 9'h0;
                    watch_frame(4, exp_d, 9, 2, 2, 4, $sformatf("stress%0d", f));
                end
            end
        join
        repeat (4) @(negedge sclk);
        check("stress queue drained", q.size(), 32'd0);
        check("stress busy after", {31'b0, busy4}, 32'd0);
        check("stress count after", {30'b0, cnt4}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
